// File: rtl/axis_frame_fifo.sv
// rtl/axis_frame_fifo.sv - store-and-forward AXI-Stream frame buffer with whole-frame drop on overflow
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   s_axis_*            input stream (tdata/tkeep/tvalid/tlast, trdy out)
//   m_axis_*            output stream (tdata/tkeep/tvalid/tlast, trdy in)
//   frame_drop          one-cycle pulse per dropped frame
//   frame_count         committed frames not yet fully read out
module axis_frame_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_trdy,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_trdy,
    output logic                  frame_drop,
    output logic [ADDR_WIDTH:0]   frame_count
);

    localparam int W = DATA_WIDTH + KEEP_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} state_t;

    state_t state, state_nx;

    logic [W-1:0]        mem [DEPTH];
    logic [ADDR_WIDTH:0] wr_cur;      // speculative write pointer
    logic [ADDR_WIDTH:0] wr_commit;   // end of last complete frame
    logic [ADDR_WIDTH:0] commit_vis;  // wr_commit as seen by the read side
    logic [ADDR_WIDTH:0] rd_ptr;

    logic       accept;
    logic       full;
    logic       wr_en;
    logic       commit;
    logic       rewind;
    logic       drop_evt;
    logic       load;
    logic       fc_dec;
    logic [W-1:0] rd_word;

    assign accept  = s_axis_tvalid && s_axis_trdy;
    // Free space is zero when the pointers differ only in the wrap bit.
    assign full    = (wr_cur[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_cur[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    // The read side only ever chases the registered commit pointer, so
    // partially written frames can never leak onto m_axis.
    assign load    = (!m_axis_tvalid || m_axis_trdy) && (rd_ptr != commit_vis);
    assign fc_dec  = m_axis_tvalid && m_axis_trdy && m_axis_tlast;
    assign rd_word = mem[rd_ptr[ADDR_WIDTH-1:0]];

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        commit   = 1'b0;
        rewind   = 1'b0;
        drop_evt = 1'b0;
        case (state)
            S_IDLE, S_WRITE: begin
                if (accept) begin
                    if (!full) begin
                        wr_en = 1'b1;
                        if (s_axis_tlast) begin
                            commit   = 1'b1;
                            state_nx = S_IDLE;
                        end else begin
                            state_nx = S_WRITE;
                        end
                    end else begin
                        // Out of room: throw away everything written for this frame.
                        rewind = 1'b1;
                        if (s_axis_tlast) begin
                            drop_evt = 1'b1;
                            state_nx = S_IDLE;
                        end else begin
                            state_nx = S_DROP;
                        end
                    end
                end
            end
            S_DROP: begin
                if (accept && s_axis_tlast) begin
                    drop_evt = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cur[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            wr_cur        <= '0;
            wr_commit     <= '0;
            commit_vis    <= '0;
            rd_ptr        <= '0;
            s_axis_trdy   <= 1'b0;
            frame_drop    <= 1'b0;
            frame_count   <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            state       <= state_nx;
            s_axis_trdy <= 1'b1;
            frame_drop  <= drop_evt;
            commit_vis  <= wr_commit;

            if (wr_en) begin
                wr_cur <= wr_cur + 1'b1;
            end else if (rewind) begin
                wr_cur <= wr_commit;
            end
            if (commit) begin
                wr_commit <= wr_cur + 1'b1;
            end

            if (load) begin
                m_axis_tdata  <= rd_word[DATA_WIDTH-1:0];
                m_axis_tkeep  <= rd_word[DATA_WIDTH +: KEEP_WIDTH];
                m_axis_tlast  <= rd_word[W-1];
                m_axis_tvalid <= 1'b1;
                rd_ptr        <= rd_ptr + 1'b1;
            end else if (m_axis_trdy) begin
                m_axis_tvalid <= 1'b0;
            end

            case ({commit, fc_dec})
                2'b10:   frame_count <= frame_count + 1'b1;
                2'b01:   frame_count <= frame_count - 1'b1;
                default: frame_count <= frame_count;
            endcase
        end
    end

endmodule
